// File: rtl/add_pipe_if.sv
// Valid/ready operand and result streams of the pipelined adder.
// The producer/consumer side uses the master modport; the adder uses slave.
interface add_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             ovf;

    modport master (
        output in_valid, a, b, mode, out_ready,
        input  in_ready, out_valid, y, ovf
    );

    modport slave (
        input  in_valid, a, b, mode, out_ready,
        output in_ready, out_valid, y, ovf
    );
endinterface

// File: rtl/add_pipe.sv
// Pipelined two-operand adder with valid/ready flow control, per-transaction
// overflow mode (wrap / unsigned saturate / signed saturate), overflow flag
// and a saturating count of overflowed results handed to the consumer.
// The sum is formed in front of stage 0; later stages only carry it along.
module add_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    add_pipe_if.slave        bus,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] ovf_count
);

    // Returns {ovf, result} for one transaction; mode 11 behaves as wrap.
    function automatic logic [WIDTH:0] add_ovf(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [1:0]       mode
    );
        logic        [WIDTH:0]   sum_u;
        logic signed [WIDTH:0]   sum_s;
        logic        [WIDTH-1:0] res;
        logic                    o;
        sum_u = {1'b0, a} + {1'b0, b};
        sum_s = $signed({a[WIDTH-1], a}) + $signed({b[WIDTH-1], b});
        res   = sum_u[WIDTH-1:0];
        o     = sum_u[WIDTH];
        case (mode)
            2'b01: begin
                if (sum_u[WIDTH]) res = '1;
            end
            2'b10: begin
                // Sign-extended sum whose top two bits disagree left the range.
                o   = sum_s[WIDTH] ^ sum_s[WIDTH-1];
                res = sum_s[WIDTH-1:0];
                if (o) res = sum_s[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}}
                                          : {1'b0, {(WIDTH-1){1'b1}}};
            end
            default: ;
        endcase
        return {o, res};
    endfunction

    logic [STAGES-1:0] vld_p;
    logic [STAGES-1:0] ovf_p;
    logic [WIDTH-1:0]  y_p [STAGES];
    logic [STAGES-1:0] adv;
    logic              hold_q;
    logic              in_ready_c;
    logic              accept;
    logic [WIDTH:0]    res_in;
    logic              fire;

    // Advance chain: a stage moves when it is empty or everything downstream moves.
    always_comb begin
        logic chain;
        adv   = '0;
        chain = !vld_p[STAGES-1] || bus.out_ready;
        adv[STAGES-1] = chain;
        for (int k = STAGES - 2; k >= 0; k--) begin
            chain  = !vld_p[k] || chain;
            adv[k] = chain;
        end
    end

    assign in_ready_c    = adv[0] && !hold_q;
    assign accept        = bus.in_valid && in_ready_c;
    assign res_in        = add_ovf(bus.a, bus.b, bus.mode);
    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = vld_p[STAGES-1];
    assign bus.y         = y_p[STAGES-1];
    assign bus.ovf       = ovf_p[STAGES-1];
    assign fire          = vld_p[STAGES-1] && bus.out_ready && ovf_p[STAGES-1];

    // Keeps in_ready low for the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hold_q <= 1'b1;
        else        hold_q <= 1'b0;
    end

    // Stage 0 captures the computed result; later stages shift it downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p <= '0;
            ovf_p <= '0;
            for (int k = 0; k < STAGES; k++) y_p[k] <= '0;
        end else begin
            // stage 0: arithmetic result enters the pipe
            if (adv[0]) begin
                vld_p[0] <= accept;
                if (accept) begin
                    ovf_p[0] <= res_in[WIDTH];
                    y_p[0]   <= res_in[WIDTH-1:0];
                end
            end
            // stages 1..STAGES-1: delay only
            for (int k = 1; k < STAGES; k++) begin
                if (adv[k]) begin
                    vld_p[k] <= vld_p[k-1];
                    if (vld_p[k-1]) begin
                        ovf_p[k] <= ovf_p[k-1];
                        y_p[k]   <= y_p[k-1];
                    end
                end
            end
        end
    end

    // Counts delivered overflowed results; a clear coinciding with one keeps it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_count <= '0;
        end else if (cnt_clr) begin
            ovf_count <= fire ? CNT_W'(1) : '0;
        end else if (fire && (ovf_count != '1)) begin
            ovf_count <= ovf_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_add_pipe.sv
// Self-checking bench for add_pipe: directed vectors, backpressure, counter
// and reset scenarios, plus a randomized run against a transaction model.
module tb_add_pipe;
    localparam int W      = 8;
    localparam int STAGES = 2;
    localparam int MAXU   = (1 << W) - 1;
    localparam int HALF   = 1 << (W - 1);

    typedef struct { int y; int o; } res_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cnt_clr = 1'b0;
    logic [15:0] ovf_count;
    logic [1:0]  ovf_count2;

    add_pipe_if #(.WIDTH(W)) bus ();
    add_pipe_if #(.WIDTH(W)) bus2 ();

    add_pipe #(.WIDTH(W), .STAGES(STAGES), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave),
        .cnt_clr(cnt_clr), .ovf_count(ovf_count)
    );

    // Second copy with a 2-bit counter sees identical stimulus.
    add_pipe #(.WIDTH(W), .STAGES(STAGES), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2.slave),
        .cnt_clr(cnt_clr), .ovf_count(ovf_count2)
    );

    assign bus2.in_valid  = bus.in_valid;
    assign bus2.a         = bus.a;
    assign bus2.b         = bus.b;
    assign bus2.mode      = bus.mode;
    assign bus2.out_ready = bus.out_ready;

    always #5 clk = ~clk;

    int   tests = 0;
    int   failed = 0;
    res_t q[$];
    int   del_log[$];
    int   model_cnt = 0;
    int   del_cnt = 0;
    bit   hold = 1'b1;
    bit   last_acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference result from the arithmetic rules on plain integers.
    function automatic res_t ref_add(input int a, input int b, input int m);
        res_t r;
        int s, sa, sb;
        case (m)
            1: begin
                s = a + b;
                r.o = (s > MAXU);
                r.y = r.o ? MAXU : s;
            end
            2: begin
                sa = (a >= HALF) ? a - (1 << W) : a;
                sb = (b >= HALF) ? b - (1 << W) : b;
                s  = sa + sb;
                if (s > HALF - 1) begin r.y = HALF - 1; r.o = 1; end
                else if (s < -HALF) begin r.y = HALF; r.o = 1; end
                else begin r.y = (s < 0) ? s + (1 << W) : s; r.o = 0; end
            end
            default: begin
                s = a + b;
                r.y = s % (1 << W);
                r.o = (s > MAXU);
            end
        endcase
        return r;
    endfunction

    // One clock cycle: check outputs mid-cycle, update model, pass the edge.
    task automatic step();
        res_t f;
        bit   acc, del, ev;
        int   exp_rdy;
        int   c2;
        @(negedge clk);
        exp_rdy = (!hold && (q.size() < STAGES || bus.out_ready)) ? 1 : 0;
        chk("in_ready", bus.in_ready, exp_rdy);
        if (q.size() == 0) begin
            chk("out_valid_empty", bus.out_valid, 0);
        end else if (bus.out_valid) begin
            chk("y", bus.y, q[0].y);
            chk("ovf", bus.ovf, q[0].o);
        end
        chk("ovf_count", ovf_count, model_cnt);
        c2 = (model_cnt > 3) ? 3 : model_cnt;
        chk("ovf_count_w2", ovf_count2, c2);
        acc = bus.in_valid && bus.in_ready;
        del = bus.out_valid && bus.out_ready;
        last_acc = acc;
        ev = 1'b0;
        if (del && q.size() > 0) begin
            f = q.pop_front();
            del_log.push_back(f.y);
            del_cnt++;
            ev = (f.o != 0);
        end
        if (cnt_clr) model_cnt = ev ? 1 : 0;
        else if (ev && model_cnt < 65535) model_cnt++;
        if (acc) q.push_back(ref_add(int'(bus.a), int'(bus.b), int'(bus.mode)));
        @(posedge clk);
        hold = 1'b0;
        #1;
    endtask

    // Issue one transaction into an empty pipe and check it emerges on time.
    task automatic direct(input int a, input int b, input int m, input int ey, input int eo);
        bus.in_valid = 1'b1;
        bus.a = W'(a);
        bus.b = W'(b);
        bus.mode = 2'(m);
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < STAGES - 1; i++) begin
            chk("latency_early", bus.out_valid, 0);
            step();
        end
        chk("latency_valid", bus.out_valid, 1);
        chk("direct_y", bus.y, ey);
        chk("direct_ovf", bus.ovf, eo);
    endtask

    task automatic drain();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20 && q.size() > 0; i++) step();
        step();
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int k, start, lstart;
        int va[7], vb[7], vm[7], vy[7], vo[7];
        va = '{3, 200, 100, 'h70, 'h90, 'h90, 200};
        vb = '{4, 100, 100, 'h20, 'h90, 'h10, 100};
        vm = '{0, 1, 1, 2, 2, 2, 3};
        vy = '{7, 255, 200, 'h7F, 'h80, 'hA0, 44};
        vo = '{0, 1, 0, 1, 1, 0, 1};

        // Reset held with live-looking inputs
        bus.in_valid = 1'b1; bus.a = 8'd5; bus.b = 8'd7; bus.mode = 2'b00;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_in_ready", bus.in_ready, 0);
            chk("rst_out_valid", bus.out_valid, 0);
            chk("rst_y", bus.y, 0);
            chk("rst_cnt", ovf_count, 0);
            @(posedge clk);
        end
        #1 rst_n = 1'b1;
        hold = 1'b1;
        step();
        chk("hold_not_accepted", last_acc, 0);
        step();
        chk("first_accept", last_acc, 1);
        drain();

        // Wrap latency and exact values
        direct(200, 100, 0, 44, 1);
        step();
        for (int i = 0; i < 7; i++) begin
            direct(va[i], vb[i], vm[i], vy[i], vo[i]);
            step();
        end
        drain();

        // Back-to-back throughput with mixed modes
        start = del_cnt;
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = 1'b1;
            bus.a = W'($urandom_range(0, MAXU));
            bus.b = W'($urandom_range(0, MAXU));
            bus.mode = 2'($urandom_range(0, 3));
            step();
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < STAGES - 1; i++) step();
        chk("burst_delivered_7", del_cnt - start, 7);
        step();
        chk("burst_delivered_8", del_cnt - start, 8);
        drain();

        // Backpressure: 1+1..6+6 with consumer stalled for 5 cycles
        lstart = del_log.size();
        bus.out_ready = 1'b0;
        k = 1;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1; bus.a = W'(k); bus.b = W'(k); bus.mode = 2'b00;
            step();
            if (last_acc) k++;
        end
        chk("bp_accepted", k - 1, STAGES);
        chk("bp_in_ready", bus.in_ready, 0);
        chk("bp_hold_y", bus.y, 2);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20 && k <= 6; i++) begin
            bus.in_valid = 1'b1; bus.a = W'(k); bus.b = W'(k);
            step();
            if (last_acc) k++;
        end
        drain();
        chk("bp_count", del_log.size() - lstart, 6);
        for (int i = 0; i < 6 && lstart + i < del_log.size(); i++)
            chk("bp_order", del_log[lstart + i], 2 * (i + 1));

        // Overflow counter
        cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
        for (int i = 0; i < 3; i++) direct(200, 100, 0, 44, 1);
        step();
        chk("cnt_three", ovf_count, 3);
        direct(250, 10, 1, 255, 1);
        cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
        chk("cnt_clr_with_event", ovf_count, 1);
        bus.out_ready = 1'b0;
        direct('h90, 'h90, 2, 'h80, 1);
        for (int i = 0; i < 3; i++) step();
        chk("cnt_held_not_counted", ovf_count, 1);
        bus.out_ready = 1'b1;
        step();
        chk("cnt_after_accept", ovf_count, 2);
        for (int i = 0; i < 4; i++) direct('h70, 'h20, 2, 'h7F, 1);
        step();
        chk("cnt_six", ovf_count, 6);
        chk("cnt_w2_sticks", ovf_count2, 3);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.out_ready = ($urandom_range(0, 9) < 7);
            cnt_clr       = ($urandom_range(0, 19) == 0);
            bus.a    = W'($urandom_range(0, MAXU));
            bus.b    = W'($urandom_range(0, MAXU));
            bus.mode = 2'($urandom_range(0, 3));
            step();
        end
        cnt_clr = 1'b0;
        drain();

        // Mid-operation reset with two entries in flight
        bus.out_ready = 1'b0;
        direct(200, 100, 0, 44, 1);
        bus.in_valid = 1'b1; bus.a = 8'd1; bus.b = 8'd2;
        step();
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_y", bus.y, 0);
        chk("midrst_cnt", ovf_count, 0);
        chk("midrst_in_ready", bus.in_ready, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        q.delete();
        model_cnt = 0;
        hold = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("midrst_no_stale", del_cnt >= 0 && q.size() == 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/add_pipe.md
# add_pipe

Parametrised, pipelined two-operand adder with valid/ready flow control, per-transaction overflow mode (wrap, unsigned saturate, signed saturate), overflow flag and a saturating overflow-event counter. It replaces the single-cycle registered adder in datapaths that need backpressure, configurable latency and saturating arithmetic. It sits between an upstream operand producer and a downstream consumer, both using valid/ready.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)
- STAGES, 2, pipeline depth in register stages (1..4)
- CNT_W, 16, overflow counter width
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operands/mode valid
- in_ready  output  1  block can accept this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- mode  input  2  00 wrap, 01 unsigned saturate, 10 signed saturate, 11 reserved (treated as 00)
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- y  output  WIDTH  result
- ovf  output  1  overflow flag for the result on y
- cnt_clr  input  1  synchronous clear of ovf_count
- ovf_count  output  CNT_W  number of overflowed results delivered, saturating

## Operation
- Accept: in_valid && in_ready at a rising edge; a, b, mode captured into stage 0.
- Arithmetic computed combinationally from inputs and registered in stage 0; later stages only delay {y, ovf, valid}.
- mode 00/11: y = (a+b) mod 2^WIDTH; ovf = unsigned carry-out.
- mode 01: unsigned; on carry y = 2^WIDTH−1, ovf=1; else exact sum, ovf=0.
- mode 10: two's complement; ovf=1 when operand signs match and sum sign differs; positive overflow → y = 2^(WIDTH−1)−1, negative → y = −2^(WIDTH−1); otherwise wrapped sum, ovf=0.
- Mode is per transaction; changing mode never affects entries already in flight.
- Stage k advances when it is empty or stage k+1 advances; last stage advances when !out_valid or out_ready. in_ready = stage 0 advances and not in the post-reset hold cycle.
- y, ovf, out_valid come from the last stage; held stable while out_valid && !out_ready.
- Counter: increments by 1 on each out_valid && out_ready with ovf=1; sticks at 2^CNT_W−1. cnt_clr sets 0; cnt_clr and a counted event in the same cycle → 1 (event not lost).
- No drops, duplicates or reordering; capacity is exactly STAGES entries.

## Timing
- Reset (rst_n low, asynchronous): all stage valids, y, ovf, out_valid, ovf_count = 0; in_ready = 0.
- Post-reset hold: for the first rising edge after rst_n rises, in_ready stays 0 and outputs stay 0; in_ready may rise after that edge.
- Latency: a transaction accepted at edge N appears on y/out_valid after edge N+STAGES−1 (STAGES=1 equals a plain registered adder), given no backpressure.
- Throughput: one transaction per cycle with out_ready held high.
- Full pipeline with out_ready=0: in_ready=0 combinationally in the same cycle; a simultaneous out_ready=1 and in_valid=1 on a full pipe accepts and delivers in that same edge.
- Reset mid-operation: all in-flight entries discarded immediately; counter cleared; no partial result is presented after release.
- in_ready depends combinationally on out_ready; there is no combinational path from a, b or mode to any output.

## Test plan
- Reset: rst_n low 3 cycles with in_valid=1, a=5, b=7 → y=0, out_valid=0, in_ready=0; first edge after release in_ready=0; next cycle in_ready=1; nothing emerges from pre-release inputs.
- Wrap (WIDTH=8, STAGES=2, mode 00): 200+100 → y=44, ovf=1 exactly 2 cycles after accept; 3+4 → y=7, ovf=0; back-to-back issue gives one result per cycle.
- Saturate: mode 01 200+100 → 255, ovf=1; 100+100 → 200, ovf=0; mode 10 0x70+0x20 → 0x7F, ovf=1; 0x90+0x90 → 0x80, ovf=1; 0x90+0x10 → 0xA0, ovf=0; mixed modes in consecutive cycles each honoured.
- Backpressure: issue 6 transactions 1+1..6+6 while out_ready=0 for 5 cycles → only 2 accepted, in_ready low, y=2 held stable; release → outputs 2,4,6,8,10,12 in order, none lost or repeated.
- Counter: deliver 3 overflowed results → ovf_count=3; cnt_clr with an overflowed delivery same cycle → 1; CNT_W=2 with 5 overflows → sticks at 3; overflowed result held by out_ready=0 is not counted until accepted.
- Mid-op reset: 2 entries in flight, pulse rst_n low for 1 cycle → out_valid=0, y=0, ovf_count=0 immediately; after release no stale result appears.
